// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel strobe, raster counters, syncs, pulses and fine-scrollable character-cell counters
module video_timing_gen #(
    parameter int HSZ       = 10,
    parameter int VSZ       = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int PIX_DIV   = 4,
    parameter int CELL_W    = 8,
    parameter int CELL_H    = 12,
    parameter int FRAME_W   = 6
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [$clog2(CELL_W)-1:0]   i_fine_x,
    input  logic [$clog2(CELL_H)-1:0]   i_fine_y,
    output logic                        o_pix_stb,
    output logic [HSZ-1:0]              o_hcount,
    output logic [VSZ-1:0]              o_vcount,
    output logic                        o_de,
    output logic                        o_hsync,
    output logic                        o_vsync,
    output logic                        o_line_start,
    output logic                        o_frame_start,
    output logic                        o_vblank_start,
    output logic [$clog2(CELL_W)-1:0]   o_cell_col,
    output logic [$clog2(CELL_H)-1:0]   o_cell_row,
    output logic [HSZ-1:0]              o_text_col,
    output logic [VSZ-1:0]              o_text_row,
    output logic [FRAME_W-1:0]          o_frame_count
);
    localparam int CXW = $clog2(CELL_W);
    localparam int CYW = $clog2(CELL_H);
    localparam int DW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0]  DMAX = DW'(PIX_DIV - 1);
    localparam logic [HSZ-1:0] HA   = HSZ'(H_ACTIVE);
    localparam logic [HSZ-1:0] HS0  = HSZ'(H_ACTIVE + H_FP);
    localparam logic [HSZ-1:0] HS1  = HSZ'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HSZ-1:0] HT1  = HSZ'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VSZ-1:0] VA   = VSZ'(V_ACTIVE);
    localparam logic [VSZ-1:0] VS0  = VSZ'(V_ACTIVE + V_FP);
    localparam logic [VSZ-1:0] VS1  = VSZ'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VSZ-1:0] VT1  = VSZ'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CXW-1:0] CXM  = CXW'(CELL_W - 1);
    localparam logic [CYW-1:0] CYM  = CYW'(CELL_H - 1);
    localparam logic HP = (HSYNC_POL != 0);
    localparam logic VP = (VSYNC_POL != 0);

    logic [DW-1:0]  div, div_n;
    logic           adv;
    logic [HSZ-1:0] h_n;
    logic [VSZ-1:0] v_n;
    logic           line_n, frame_n, vbl_n, row_reload, row_step, col_wrap, row_wrap;
    logic [CXW-1:0] fx_lat, fx_eff, cell_col_n;
    logic [CYW-1:0] fy_lat, fy_eff, cell_row_n;
    logic [HSZ-1:0] text_col_n;
    logic [VSZ-1:0] text_row_n;

    // next raster position and next cell-counter values, applied only on advance edges
    always_comb begin
        adv        = (div == DMAX);
        div_n      = adv ? '0 : div + 1'b1;
        h_n        = (o_hcount == HT1) ? '0 : o_hcount + 1'b1;
        v_n        = (o_hcount != HT1) ? o_vcount : (o_vcount == VT1) ? '0 : o_vcount + 1'b1;
        line_n     = (h_n == '0);
        frame_n    = line_n && (v_n == '0);
        vbl_n      = line_n && (v_n == VA);
        fx_eff     = frame_n ? ((i_fine_x > CXM) ? '0 : i_fine_x) : fx_lat;
        fy_eff     = frame_n ? ((i_fine_y > CYM) ? '0 : i_fine_y) : fy_lat;
        col_wrap   = (o_cell_col == CXM);
        cell_col_n = line_n ? fx_eff : (h_n < HA) ? (col_wrap ? '0 : o_cell_col + 1'b1) : o_cell_col;
        text_col_n = line_n ? '0 : (h_n < HA && col_wrap) ? o_text_col + 1'b1 : o_text_col;
        row_wrap   = (o_cell_row == CYM);
        row_reload = line_n && (v_n == '0);
        row_step   = line_n && (v_n != '0) && (v_n < VA);
        cell_row_n = row_reload ? fy_eff : row_step ? (row_wrap ? '0 : o_cell_row + 1'b1) : o_cell_row;
        text_row_n = row_reload ? '0 : (row_step && row_wrap) ? o_text_row + 1'b1 : o_text_row;
    end

    // pixel divider and one-cycle strobe/pulses qualified by the advance edge
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            div            <= '0;
            o_pix_stb      <= 1'b0;
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
        end else begin
            div            <= div_n;
            o_pix_stb      <= adv;
            o_line_start   <= adv && line_n;
            o_frame_start  <= adv && frame_n;
            o_vblank_start <= adv && vbl_n;
        end
    end

    // raster counters, display enable and syncs
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            o_hcount <= HT1;
            o_vcount <= VT1;
            o_de     <= 1'b0;
            o_hsync  <= ~HP;
            o_vsync  <= ~VP;
        end else if (adv) begin
            o_hcount <= h_n;
            o_vcount <= v_n;
            o_de     <= (h_n < HA) && (v_n < VA);
            o_hsync  <= (h_n >= HS0 && h_n < HS1) ? HP : ~HP;
            o_vsync  <= (v_n >= VS0 && v_n < VS1) ? VP : ~VP;
        end
    end

    // fine-scroll latch, character-cell counters and completed-frame counter
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            fx_lat        <= '0;
            fy_lat        <= '0;
            o_cell_col    <= '0;
            o_cell_row    <= '0;
            o_text_col    <= '0;
            o_text_row    <= '0;
            o_frame_count <= '0;
        end else if (adv) begin
            fx_lat        <= fx_eff;
            fy_lat        <= fy_eff;
            o_cell_col    <= cell_col_n;
            o_cell_row    <= cell_row_n;
            o_text_col    <= text_col_n;
            o_text_row    <= text_row_n;
            o_frame_count <= vbl_n ? o_frame_count + 1'b1 : o_frame_count;
        end
    end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the graphics pipeline. It derives a pixel strobe from the fast system clock, produces H/V counters, sync, display-enable, and line/frame/vblank pulses for any resolution. It also generates fine-scrollable character-cell counters (glyph column/row, text column/row) and a wrapping frame counter. Downstream text, canvas and PSRAM-fetch logic run on `clk_i` and qualify their work with `o_pix_stb`.

## Interface
Parameters:
- `HSZ`, 10: width of `o_hcount` / `o_text_col`
- `VSZ`, 10: width of `o_vcount` / `o_text_row`
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines
- `HSYNC_POL`, 0; `VSYNC_POL`, 0: active sync level
- `PIX_DIV`, 4: `clk_i` cycles per pixel, ≥1
- `CELL_W`, 8; `CELL_H`, 12: character cell size, ≥2, any value
- `FRAME_W`, 6: frame counter width

Ports:
- `clk_i` in 1: system clock
- `rstn_i` in 1: reset. One clock; reset is synchronous and active-low.
- `i_fine_x` in clog2(CELL_W): horizontal cell fine-scroll
- `i_fine_y` in clog2(CELL_H): vertical cell fine-scroll
- `o_pix_stb` out 1: first `clk_i` cycle of each pixel period
- `o_hcount` out HSZ; `o_vcount` out VSZ: raster position
- `o_de` out 1: active region
- `o_hsync` out 1; `o_vsync` out 1: sync outputs
- `o_line_start` out 1; `o_frame_start` out 1; `o_vblank_start` out 1: one-cycle pulses
- `o_cell_col` out clog2(CELL_W); `o_cell_row` out clog2(CELL_H): pixel within cell
- `o_text_col` out HSZ; `o_text_row` out VSZ: cell index
- `o_frame_count` out FRAME_W: completed frames, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider `div` counts 0..PIX_DIV-1 and wraps. The **advance edge** is the edge where `div==PIX_DIV-1`. With PIX_DIV=1, every edge is an advance edge.
- On an advance edge:
  - `h` increments; at H_TOTAL-1 it wraps to 0 and `v` increments.
  - At V_TOTAL-1 with `h` wrapping, `v` wraps to 0.
- `o_de` = h<H_ACTIVE && v<V_ACTIVE.
- `o_hsync` = HSYNC_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL. `o_vsync` follows the same rule on `v`.
- Fine-scroll latching:
  - At each frame start (advance to h=0,v=0), `i_fine_x` and `i_fine_y` are latched.
  - A latched value ≥ CELL_W (resp. CELL_H) is treated as 0.
  - Mid-frame input changes have no effect.
- Horizontal cell counters:
  - At h=0, `o_cell_col` = latched fine_x and `o_text_col`=0.
  - Each advance while the next h < H_ACTIVE, `o_cell_col` increments.
  - On CELL_W-1 → 0, `o_text_col` increments.
  - Both counters hold during horizontal blanking.
- Vertical cell counters:
  - At v=0, `o_cell_row` = latched fine_y and `o_text_row`=0.
  - At each line start with the new v in 1..V_ACTIVE-1, `o_cell_row` increments.
  - On CELL_H-1 → 0, `o_text_row` increments.
  - Both counters hold during vertical blanking.
- `o_frame_count` increments (mod 2^FRAME_W) on the advance into v=V_ACTIVE, h=0, coincident with `o_vblank_start`.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Timing
- Reset state while `rstn_i`=0, sampled on `clk_i`:
  - div=0; h=H_TOTAL-1; v=V_TOTAL-1.
  - `o_pix_stb`, `o_de`, all pulses = 0.
  - Syncs at their inactive level.
  - Cell/text counters 0; `o_frame_count`=0; latched fine values 0.
- First advance edge after release is PIX_DIV edges later. It yields h=0, v=0, with `o_pix_stb`, `o_line_start` and `o_frame_start` all high for that one cycle.
- Every output changes only on an advance edge. It is valid from the cycle where `o_pix_stb`=1 for PIX_DIV cycles.
- Pulse timing:
  - `o_line_start` = `o_pix_stb` && h==0.
  - `o_frame_start` = `o_pix_stb` && h==0 && v==0.
  - `o_vblank_start` = `o_pix_stb` && h==0 && v==V_ACTIVE.
  - Each pulse is exactly one `clk_i` wide.
- Reset asserted mid-line or mid-frame returns all state to the reset values on the next edge. There is no partial line.
- Frame period is exactly H_TOTAL·V_TOTAL·PIX_DIV `clk_i` cycles.

## Test plan
Small-config parameters: H 8/2/2/2, V 4/1/1/1, PIX_DIV=2, CELL_W=3, CELL_H=2.

- **Reset release:** release reset. The 2nd edge gives h=0, v=0 with `o_pix_stb`=`o_frame_start`=`o_line_start`=1 for 1 cycle. `o_pix_stb` then repeats every 2 cycles. The frame period is 14·7·2=196 cycles.
- **Sync and DE:** check `o_hsync` low only for h∈{10,11}. Check `o_vsync` low only for v=5. Check `o_de` is high only for h<8 and v<4, i.e. 32 strobes per frame.
- **Fine scroll:** with fine_x=0, a line gives `o_cell_col` 0,1,2,0,1,2,0,1 and `o_text_col` 0,0,0,1,1,1,2,2. With fine_x=2 the sequence is 2,0,1,2,0,1,2,0 and `o_text_col` 0,1,1,1,2,2,2,3. Changing fine_x mid-frame takes effect only at the next `o_frame_start`.
- **Invalid fine scroll:** fine_x=3 (≥CELL_W) behaves as 0. fine_y=1 gives `o_cell_row` 1,0,1,0 and `o_text_row` 0,1,1,2 over lines 0..3.
- **Frame counter wrap:** run 64 frames with FRAME_W=6. `o_frame_count` steps 1..63 then 0, each step coincident with `o_vblank_start` at v=4.
- **Mid-frame reset:** assert reset at v=2, h=5 for 1 cycle. All outputs show reset values. The next `o_frame_start` follows 2 cycles after release.
